mem_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the 16-bit word memory. Accepts a byte stream over a valid/ready handshake, packs byte pairs big-endian into 16-bit words, and writes them to consecutive memory addresses using the memory's two-step address-then-write protocol. Optionally reads each word back and flags the first mismatch. Releases the memory port when idle so the CPU datapath can own it after boot.

---
 rtl/mem_loader.sv | 102 ++++++++++
 tb/tb_mem_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Boot-time program loader: packs a big-endian byte stream into 16-bit words and
// writes them to consecutive addresses, optionally reading each one back.
module mem_loader #(
  parameter bit VERIFY = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_addr_en,
  output logic [15:0] mem_addr,
  output logic        mem_in_en,
  output logic [15:0] mem_in,
  output logic        mem_out_en,
  input  logic [15:0] mem_out,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] err_addr
);

  typedef enum logic [2:0] {IDLE, HI, LO, ADDR, WRITE, CHECK, DONE} state_t;

  state_t      state;
  state_t      nxt;
  logic [15:0] ptr;
  logic [15:0] remaining;
  logic [15:0] word;
  logic        advance;

  assign advance = (state == CHECK) || ((state == WRITE) && !VERIFY);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (word_count != '0) ? HI : DONE;
      HI:      if (byte_valid) nxt = LO;
      LO:      if (byte_valid) nxt = ADDR;
      ADDR:    nxt = WRITE;
      WRITE:   if (VERIFY) nxt = CHECK;
               else        nxt = (remaining == 16'd1) ? DONE : HI;
      CHECK:   nxt = (remaining == 16'd1) ? DONE : HI;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state
  // they decode while staying glitch-free at the memory port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      remaining   <= '0;
      word        <= '0;
      error       <= 1'b0;
      err_addr    <= '0;
      byte_ready  <= 1'b0;
      mem_addr_en <= 1'b0;
      mem_addr    <= '0;
      mem_in_en   <= 1'b0;
      mem_in      <= '0;
      mem_out_en  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          ptr       <= base_addr;
          remaining <= word_count;
          error     <= 1'b0;
          err_addr  <= '0;
        end
        HI:    if (byte_valid) word[15:8] <= byte_data;
        LO:    if (byte_valid) word[7:0]  <= byte_data;
        CHECK: if ((mem_out != word) && !error) begin
          error    <= 1'b1;
          err_addr <= ptr;
        end
        default: ;
      endcase
      if (advance) begin
        ptr       <= ptr + 16'd1;
        remaining <= remaining - 16'd1;
      end
      byte_ready  <= (nxt == HI) || (nxt == LO);
      mem_addr_en <= (nxt == ADDR);
      mem_addr    <= (nxt == ADDR) ? ptr : '0;
      mem_in_en   <= (nxt == WRITE);
      mem_in      <= (nxt == WRITE) ? word : '0;
      mem_out_en  <= (nxt == CHECK);
      busy        <= (nxt != IDLE);
      done        <= (nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: behavioural word memory with latched address,
// a byte feeder with optional stalls, and latency/content checks.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_addr_en;
  logic [15:0] mem_addr;
  logic        mem_in_en;
  logic [15:0] mem_in;
  logic        mem_out_en;
  logic [15:0] mem_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] err_addr;

  always #5 clk = ~clk;

  mem_loader #(.VERIFY(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_addr_en(mem_addr_en), .mem_addr(mem_addr),
    .mem_in_en(mem_in_en), .mem_in(mem_in), .mem_out_en(mem_out_en),
    .mem_out(mem_out), .busy(busy), .done(done), .error(error),
    .err_addr(err_addr)
  );

  // Word memory: address register loaded by mem_addr_en, write at latched address.
  logic [15:0] mem [0:65535];
  logic [15:0] lat = '0;
  logic        corrupt = 1'b0;
  assign mem_out = (corrupt && lat == 16'h0011) ? 16'hDEAD : mem[lat];

  int unsigned cyc = 0;
  int unsigned n_strobe = 0;
  int unsigned n_overlap = 0;
  int unsigned n_order = 0;
  int unsigned n_done = 0;
  logic        prev_addr_en = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_addr_en) lat <= mem_addr;
    if (mem_in_en) mem[lat] <= mem_in;
    if (mem_addr_en || mem_in_en || mem_out_en) n_strobe = n_strobe + 1;
    if (mem_addr_en && mem_in_en) n_overlap = n_overlap + 1;
    if (mem_in_en && !prev_addr_en) n_order = n_order + 1;
    if (done) n_done = n_done + 1;
    prev_addr_en = mem_addr_en;
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared = compared + 1;
    if (got !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] bytes [0:15];
  int         nbytes;
  int         stall;
  logic       abort_feed = 1'b0;

  // Stall cycles are counted only where the loader is actually ready for a byte.
  task automatic feed();
    int n;
    int g;
    for (int i = 0; i < nbytes && !abort_feed; i++) begin
      n = 0;
      g = 0;
      byte_valid = 1'b0;
      while (n < stall && g < 100 && !abort_feed) begin
        if (byte_ready) n++;
        @(negedge clk);
        g++;
      end
      byte_valid = 1'b1;
      byte_data  = bytes[i];
      while (!byte_ready && g < 100 && !abort_feed) begin
        @(negedge clk);
        g++;
      end
      check("feed_bound", 32'(g >= 100), 32'd0);
      if (!abort_feed) @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] b, input logic [15:0] c, input int stl,
                          input int exp_lat, input string tag);
    int t0;
    int g;
    int nb;
    @(negedge clk);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    stall      = stl;
    nbytes     = 2 * int'(c);
    abort_feed = 1'b0;
    t0         = int'(cyc);
    fork
      feed();
    join_none
    @(negedge clk);
    start = 1'b0;
    g  = 0;
    nb = 0;
    while (g < 500) begin
      if (busy) nb++;
      if (done) break;
      @(negedge clk);
      g++;
    end
    check({tag, "_latency"}, 32'(int'(cyc) - t0), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_idle_after"}, 32'({busy, done}), 32'd0);
  endtask

  task automatic set_bytes6(input logic [7:0] b0, b1, b2, b3, b4, b5);
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    bytes[3] = b3; bytes[4] = b4; bytes[5] = b5;
  endtask

  int unsigned snap;
  int          w;
  int          g;
  int          d0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    rst = 1'b0;
    start = 1'b0; base_addr = '0; word_count = '0; byte_valid = 1'b0; byte_data = '0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start      = 1'($urandom);
      base_addr  = 16'($urandom);
      word_count = 16'($urandom);
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      #1;
      check("reset_outputs", 32'({|mem_addr, |mem_in, |err_addr, byte_ready, mem_addr_en,
                                  mem_in_en, mem_out_en, busy, done, error}), 32'd0);
    end
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0; base_addr = '0; word_count = '0;
    rst = 1'b1;
    snap = n_strobe;
    repeat (5) @(negedge clk);
    check("idle_strobes", n_strobe - snap, 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic load
    set_bytes6(8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF);
    run_load(16'h0010, 16'd3, 0, 16, "basic");
    check("basic_mem10", 32'(mem[16'h0010]), 32'h1234);
    check("basic_mem11", 32'(mem[16'h0011]), 32'hABCD);
    check("basic_mem12", 32'(mem[16'h0012]), 32'h00FF);
    check("basic_error", 32'(error), 32'd0);

    // Stalled stream into cleared memory
    mem[16'h0010] = '0; mem[16'h0011] = '0; mem[16'h0012] = '0;
    run_load(16'h0010, 16'd3, 2, 28, "stall");
    check("stall_mem10", 32'(mem[16'h0010]), 32'h1234);
    check("stall_mem11", 32'(mem[16'h0011]), 32'hABCD);
    check("stall_mem12", 32'(mem[16'h0012]), 32'h00FF);
    check("stall_mem13", 32'(mem[16'h0013]), 32'h0000);

    // Address wrap then zero count
    set_bytes6(8'h11, 8'h11, 8'h22, 8'h22, 8'h00, 8'h00);
    run_load(16'hFFFF, 16'd2, 0, 11, "wrap");
    check("wrap_memffff", 32'(mem[16'hFFFF]), 32'h1111);
    check("wrap_mem0000", 32'(mem[16'h0000]), 32'h2222);
    snap = n_strobe;
    run_load(16'h0030, 16'd0, 0, 1, "zero");
    check("zero_strobes", n_strobe - snap, 32'd0);

    // Verify mismatch at 0x0011
    set_bytes6(8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF);
    corrupt = 1'b1;
    d0 = int'(n_done);
    run_load(16'h0010, 16'd3, 0, 16, "verify");
    check("verify_error", 32'(error), 32'd1);
    check("verify_err_addr", 32'(err_addr), 32'h0011);
    check("verify_done_pulses", 32'(int'(n_done) - d0), 32'd1);
    corrupt = 1'b0;
    run_load(16'h0040, 16'd0, 0, 1, "clear");
    check("clear_error", 32'(error), 32'd0);

    // Start while busy is ignored
    d0 = int'(n_done);
    fork
      run_load(16'h0010, 16'd3, 0, 16, "ignore");
      begin
        repeat (6) @(negedge clk);
        start = 1'b1; base_addr = 16'h0050; word_count = 16'd0;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check("ignore_done_pulses", 32'(int'(n_done) - d0), 32'd1);
    check("ignore_mem12", 32'(mem[16'h0012]), 32'h00FF);

    // Reset during WRITE of word 2
    set_bytes6(8'h5A, 8'h5A, 8'h66, 8'h77, 8'h88, 8'h99);
    @(negedge clk);
    base_addr = 16'h0010; word_count = 16'd3; start = 1'b1;
    stall = 0; nbytes = 6; abort_feed = 1'b0;
    fork
      feed();
    join_none
    @(negedge clk);
    start = 1'b0;
    w = 0;
    g = 0;
    while (w < 2 && g < 100) begin
      @(negedge clk);
      if (mem_in_en) w++;
      g++;
    end
    check("abort_reached_write2", 32'(w), 32'd2);
    rst = 1'b0;
    abort_feed = 1'b1;
    #1;
    check("abort_outputs", 32'({|mem_addr, |mem_in, byte_ready, mem_addr_en, mem_in_en,
                                mem_out_en, busy, done}), 32'd0);
    snap = n_strobe;
    repeat (4) @(negedge clk);
    check("abort_strobes", n_strobe - snap, 32'd0);
    check("abort_mem10", 32'(mem[16'h0010]), 32'h5A5A);
    check("abort_mem11", 32'(mem[16'h0011]), 32'hABCD);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bytes[0] = 8'h09; bytes[1] = 8'h08;
    run_load(16'h0020, 16'd1, 0, 6, "after_abort");
    check("after_abort_mem20", 32'(mem[16'h0020]), 32'h0908);

    check("strobe_overlap", n_overlap, 32'd0);
    check("write_after_addr", n_order, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
